// File: rtl/fp_norm_round_pipe.sv
// Normalize / round / pack back end for the FP add/sub datapath.
// Three register stages under a single global stall (adv).
module fp_norm_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_W-1:0]       in_exp,
   input  logic [MAN_W+4:0]       in_mant,
   input  logic [1:0]             in_rnd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic [2:0]             out_flags
);
   localparam int STAGES  = 3;
   localparam int MW      = MAN_W + 5;
   localparam int NW      = MAN_W + 4;
   localparam int LZ_W    = $clog2(MAN_W + 5);
   localparam int EW      = EXP_W + 2;
   localparam int EXP_MAX = (1 << EXP_W) - 1;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MW-1:0]    mant;
      logic [1:0]       rnd;
      logic [LZ_W-1:0]  lz;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic [EW-1:0]    exp;
      logic [NW-1:0]    norm;   // {hidden, fraction, g, r, s}
      logic [1:0]       rnd;
      logic             zero;
      logic             flush;
   } s2_t;

   logic [STAGES:1] vld_pipe;
   logic            adv;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   logic [LZ_W-1:0] lz_d;

   assign out_valid = vld_pipe[STAGES];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;

   // leading zeros counted from the hidden position down; NW when all clear
   always_comb begin
      lz_d = LZ_W'(NW);
      for (int i = 0; i < NW; i++)
         if (in_mant[i]) lz_d = LZ_W'(NW - 1 - i);
   end

   always_comb begin
      s1_d.sign = in_sign;
      s1_d.exp  = in_exp;
      s1_d.mant = in_mant;
      s1_d.rnd  = in_rnd;
      s1_d.lz   = lz_d;
   end

   logic signed [EW-1:0] exp_x, lz_x;

   always_comb begin
      exp_x      = $signed(EW'(s1_q.exp));
      lz_x       = $signed(EW'(s1_q.lz));
      s2_d.sign  = s1_q.sign;
      s2_d.rnd   = s1_q.rnd;
      s2_d.zero  = (s1_q.mant == '0);
      s2_d.flush = 1'b0;
      if (s1_q.mant[MW-1]) begin
         s2_d.norm = {s1_q.mant[MW-1:2], |s1_q.mant[1:0]};
         s2_d.exp  = exp_x + $signed(EW'(1));
      end else begin
         s2_d.norm  = s1_q.mant[NW-1:0] << s1_q.lz;
         s2_d.exp   = exp_x - lz_x;
         s2_d.flush = (lz_x >= exp_x);
      end
   end

   logic [MAN_W-1:0]     frac;
   logic                 g, r, st, x, inc;
   logic [MAN_W:0]       sum;
   logic signed [EW-1:0] e_r;
   logic [EXP_W+MAN_W:0] res_d;
   logic [2:0]           flg_d;

   always_comb begin
      frac = s2_q.norm[NW-2:3];
      g    = s2_q.norm[2];
      r    = s2_q.norm[1];
      st   = s2_q.norm[0];
      x    = g | r | st;
      case (s2_q.rnd)
         2'd0:    inc = g & (r | st | frac[0]);
         2'd1:    inc = 1'b0;
         2'd2:    inc = ~s2_q.sign & x;
         default: inc = s2_q.sign & x;
      endcase
      sum = {1'b0, frac} + (MAN_W+1)'(inc);
      e_r = $signed(s2_q.exp) + $signed(EW'(sum[MAN_W]));
      if (s2_q.zero) begin
         res_d = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
         flg_d = 3'b000;
      end else if (s2_q.flush) begin
         res_d = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
         flg_d = 3'b011;
      end else if (e_r >= $signed(EW'(EXP_MAX))) begin
         res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_d = 3'b101;
      end else begin
         res_d = {s2_q.sign, e_r[EXP_W-1:0], sum[MAN_W-1:0]};
         flg_d = {2'b00, x};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe   <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (adv) begin
         vld_pipe   <= {vld_pipe[STAGES-1:1], in_valid};
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         out_result <= res_d;
         out_flags  <= flg_d;
      end
   end
endmodule
